// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-16 demux tree.
//   DEMUX_OUT_W : width of the demux output vector
//   DEMUX_SEL_W : width of the output index
//   LEAF_W      : width of one 1-to-4 leaf demux output
//   Y_RESET     : value of the output register while in reset
package demux_pkg;
  localparam int DEMUX_OUT_W = 16;
  localparam int DEMUX_SEL_W = 4;
  localparam int LEAF_W      = 4;

  localparam logic [DEMUX_OUT_W-1:0] Y_RESET = 16'h0000;
endpackage

// File: rtl/demux1_4.sv
// Combinational 1-to-4 demultiplexer.
//   in  : data bit
//   sel : 2-bit output index
//   y   : 4-bit output; y[sel] = in, all other bits 0
module demux1_4
  import demux_pkg::*;
(
  input  logic              in,
  input  logic [1:0]        sel,
  output logic [LEAF_W-1:0] y
);

  always_comb begin
    y = '0;
    for (int k = 0; k < LEAF_W; k++) begin
      if (sel == k[1:0]) y[k] = in;
    end
  end

endmodule

// File: rtl/demux1_16_using1_4_demux.sv
// 1-to-16 single-bit demultiplexer built from a two-level tree of 1-to-4
// demuxes, followed by a registered output stage (1-cycle latency).
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, clears y
//   in    : data bit to route
//   sel   : output index 0..15
//   y     : registered output, at most one bit set
module demux1_16_using1_4_demux
  import demux_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in,
  input  logic [DEMUX_SEL_W-1:0] sel,
  output logic [DEMUX_OUT_W-1:0] y
);

  logic [LEAF_W-1:0]      grp;     // stage-1 group lines, one per nibble
  logic [DEMUX_OUT_W-1:0] y_next;  // combinational tree output

  // Stage 1: sel[3:2] picks which nibble receives the data bit.
  demux1_4 u_stage1 (
    .in  (in),
    .sel (sel[3:2]),
    .y   (grp)
  );

  // Stage 2: each group line is spread across its own nibble by sel[1:0].
  for (genvar g = 0; g < 4; g++) begin : g_leaf
    demux1_4 u_leaf (
      .in  (grp[g]),
      .sel (sel[1:0]),
      .y   (y_next[LEAF_W*g +: LEAF_W])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) y <= Y_RESET;
    else        y <= y_next;
  end

endmodule

// File: tb/tb_demux1_16_using1_4_demux.sv
// Self-checking bench for demux1_16_using1_4_demux.
module tb_demux1_16_using1_4_demux;
  logic        clk;
  logic        rst_n;
  logic        in;
  logic [3:0]  sel;
  logic [15:0] y;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  bit          reset_seen = 0;

  demux1_16_using1_4_demux dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .sel   (sel),
    .y     (y)
  );

  // Clock / initial input state
  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    in    = 1'b1;
    sel   = 4'd5;
    forever #5 clk = ~clk;
  end

  // Reference model: at each rising edge, what y must become.
  always @(posedge clk) begin
    logic [15:0] e;
    if (!rst_n) reset_seen = 1;
    if (reset_seen) begin
      if (!rst_n)  e = 16'h0000;
      else if (in) e = 16'h0001 << sel;
      else         e = 16'h0000;
      exp_q.push_back(e);
    end
  end

  // Compare process: one check per modelled edge, half a cycle later.
  always @(negedge clk) begin
    logic [15:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (y !== e) begin
        failures++;
        $display("FAIL model: y=%h expected=%h at %0t", y, e, $time);
      end
      checks++;
      if ($countones(y) > 1) begin
        failures++;
        $display("FAIL onehot: y=%h has %0d bits set, at most 1 allowed", y, $countones(y));
      end
    end
  end

  // Driver: apply inputs away from the rising edge.
  task automatic step(input logic r, input logic i, input logic [3:0] s);
    @(negedge clk);
    rst_n = r;
    in    = i;
    sel   = s;
  endtask

  // Literal check of y just after the edge that sampled the last step.
  task automatic check_lit(input string name, input logic [15:0] want);
    @(posedge clk);
    #1;
    checks++;
    if (y !== want) begin
      failures++;
      $display("FAIL %s: y=%h expected=%h", name, y, want);
    end
  endtask

  logic [3:0]  nib_sel [6] = '{4'd3, 4'd4, 4'd7, 4'd8, 4'd11, 4'd12};
  logic [15:0] nib_exp [6] = '{16'h0008, 16'h0010, 16'h0080, 16'h0100, 16'h0800, 16'h1000};
  logic        tog_in  [3] = '{1'b1, 1'b0, 1'b1};
  logic [15:0] tog_exp [3] = '{16'h8000, 16'h0000, 16'h8000};

  initial begin
    // Reset held for two edges with live data on the inputs
    step(1'b0, 1'b1, 4'd5); check_lit("reset_hold0", 16'h0000);
    step(1'b0, 1'b1, 4'd5); check_lit("reset_hold1", 16'h0000);
    step(1'b1, 1'b1, 4'd5); check_lit("reset_release", 16'h0020);

    // Sweep with in=1 (model checks every value; a few pinned literally)
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 4'(i));
      if (i == 0)  check_lit("sweep1_sel0",  16'h0001);
      if (i == 6)  check_lit("sweep1_sel6",  16'h0040);
      if (i == 15) check_lit("sweep1_sel15", 16'h8000);
    end

    // Sweep with in=0
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 4'(i));
      if (i == 13) check_lit("sweep0_sel13", 16'h0000);
    end

    // Nibble boundaries
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, nib_sel[i]);
      check_lit($sformatf("nibble_sel%0d", nib_sel[i]), nib_exp[i]);
    end

    // Toggle in at sel=15
    for (int i = 0; i < 3; i++) begin
      step(1'b1, tog_in[i], 4'd15);
      check_lit($sformatf("toggle%0d", i), tog_exp[i]);
    end

    // Reset mid-sweep
    step(1'b1, 1'b1, 4'd8);  check_lit("midsweep_pre", 16'h0100);
    step(1'b0, 1'b1, 4'd9);  check_lit("midsweep_reset", 16'h0000);
    step(1'b1, 1'b1, 4'd10); check_lit("midsweep_release", 16'h0400);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)));
    end

    // Let the last expectations drain
    step(1'b1, 1'b0, 4'd0);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() > 1) begin
      failures++;
      $display("FAIL drain: %0d expectations left, at most 1 allowed", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
